// File: rtl/bpu_pht_ctrl.sv
// PHT RAM controller: clear sweeps after reset/flush, in-order update queue,
// and single-port arbitration between fetch lookups and queued updates.
module bpu_pht_ctrl #(
    parameter int unsigned INDEX_W   = 8,
    parameter int unsigned ENTRY_NUM = 256,
    parameter int unsigned DATA_W    = 56,
    parameter int unsigned QDEPTH    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = {2'b11, {(DATA_W-2){1'b0}}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_req,
    input  logic               rd_req,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_grant,
    output logic               rd_data_valid,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [DATA_W-1:0]  upd_data,
    output logic               upd_ready,
    output logic               ram_en,
    output logic               ram_we,
    output logic [INDEX_W-1:0] ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               busy_init
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [INDEX_W:0]   sweep_q, sweep_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rdv_q, rdv_d;
    logic [INDEX_W-1:0] qidx_q  [QDEPTH];
    logic [DATA_W-1:0]  qdata_q [QDEPTH];

    logic run, sweeping, q_full, q_empty, wr_grant, push, pop, sweep_last;

    // Arbitration: a full queue, or a pending update with no lookup, owns the port
    always_comb begin
        run        = (state_q == ST_RUN);
        sweeping   = !run;
        q_full     = (count_q == CNT_W'(QDEPTH));
        q_empty    = (count_q == '0);
        sweep_last = (sweep_q == (INDEX_W+1)'(ENTRY_NUM - 1));
        wr_grant   = !reset && run && (q_full || (!q_empty && !rd_req));
        rd_grant   = !reset && run && rd_req && !wr_grant;
        upd_ready  = !reset && run && !q_full;
        push       = upd_valid && upd_ready;
        pop        = wr_grant;
        busy_init  = sweeping;
    end

    // RAM port drive: sweep write, queued write, lookup, or idle; all zero in reset
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset) begin
            if (sweeping) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = sweep_q[INDEX_W-1:0];
                ram_wdata = CLEAR_VALUE;
            end else if (wr_grant) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = qidx_q[rptr_q];
                ram_wdata = qdata_q[rptr_q];
            end else if (rd_grant) begin
                ram_en    = 1'b1;
                ram_addr  = rd_index;
            end
        end
    end

    // Next-state: sweep progress, queue pointers/count, flush restart
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        // Read-valid never crosses into a sweep, even for a lookup granted in the flush cycle
        rdv_d   = rd_grant && !flush_req;
        if (run) begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end else begin
            sweep_d = sweep_q + (INDEX_W+1)'(1);
            if (sweep_last) state_d = ST_RUN;
        end
        if (flush_req) begin
            state_d = ST_FLUSH;
            sweep_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    // Control registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            rdv_q   <= rdv_d;
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            qidx_q[wptr_q]  <= upd_index;
            qdata_q[wptr_q] <= upd_data;
        end
    end

    assign rd_data_valid = rdv_q;

endmodule

// File: tb/tb_bpu_pht_ctrl.sv
// Directed testbench for bpu_pht_ctrl: vector table for RUN arbitration plus
// hand-written sweep, flush and reset sequences.
module tb_bpu_pht_ctrl;

    localparam logic [55:0] CLR = {2'b11, 54'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush_req = 1'b0, rd_req = 1'b0, upd_valid = 1'b0;
    logic [7:0]  rd_index = '0, upd_index = '0;
    logic [55:0] upd_data = '0;
    logic        rd_grant, rd_data_valid, upd_ready, ram_en, ram_we, busy_init;
    logic [7:0]  ram_addr;
    logic [55:0] ram_wdata;

    int checks = 0;
    int errors = 0;
    logic [255:0] written = '0;

    always #5 clk = ~clk;

    bpu_pht_ctrl #(.INDEX_W(8), .ENTRY_NUM(256), .DATA_W(56), .QDEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req),
        .rd_req(rd_req), .rd_index(rd_index), .rd_grant(rd_grant),
        .rd_data_valid(rd_data_valid), .upd_valid(upd_valid),
        .upd_index(upd_index), .upd_data(upd_data), .upd_ready(upd_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy_init(busy_init)
    );

    // Record every index written by an update (outside sweeps)
    always @(negedge clk) begin
        if (!reset && ram_en && ram_we && !busy_init) written[ram_addr] <= 1'b1;
    end

    typedef struct {
        logic rd; logic [7:0] ridx;
        logic uv; logic [7:0] uidx; logic [55:0] ud;
        logic en; logic we; logic [7:0] addr; logic [55:0] wd;
        logic gnt; logic rdy; logic rdv;
    } vec_t;

    function automatic logic [55:0] D(input logic [7:0] i, input logic [1:0] c);
        return {c, 14'h0, i, 24'h0, i};
    endfunction

    function automatic vec_t mk(input logic rd, input logic [7:0] ridx,
                                input logic uv, input logic [7:0] uidx, input logic [55:0] ud,
                                input logic en, input logic we, input logic [7:0] addr,
                                input logic [55:0] wd, input logic gnt, input logic rdy,
                                input logic rdv);
        vec_t v;
        v.rd = rd; v.ridx = ridx; v.uv = uv; v.uidx = uidx; v.ud = ud;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.gnt = gnt; v.rdy = rdy; v.rdv = rdv;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expect n consecutive clear-sweep cycles at addresses 0..n-1
    task automatic check_sweep(input string nm, input int n);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (!(ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 8'(i) &&
                  ram_wdata === CLR && busy_init === 1'b1 && rd_grant === 1'b0 &&
                  upd_ready === 1'b0 && rd_data_valid === 1'b0)) begin
                if (bad == 0) first = i;
                bad++;
            end
            tick();
        end
        if (bad != 0) $display("  first bad sweep cycle %0d in %s", first, nm);
        chk(nm, 64'(bad), 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(1, 8'h05, 1, 8'h10, D(8'h10, 1), 1, 0, 8'h05, '0, 1, 1, 0);
        vecs[1]  = mk(1, 8'h06, 1, 8'h20, D(8'h20, 1), 1, 0, 8'h06, '0, 1, 1, 1);
        vecs[2]  = mk(1, 8'h07, 1, 8'h30, D(8'h30, 2), 1, 0, 8'h07, '0, 1, 1, 1);
        vecs[3]  = mk(1, 8'h08, 1, 8'h40, D(8'h40, 0), 1, 0, 8'h08, '0, 1, 1, 1);
        vecs[4]  = mk(1, 8'h09, 1, 8'h55, D(8'h55, 3), 1, 1, 8'h10, D(8'h10, 1), 0, 0, 1);
        vecs[5]  = mk(1, 8'h0A, 0, 8'h00, '0,          1, 0, 8'h0A, '0, 1, 1, 0);
        vecs[6]  = mk(0, 8'h00, 0, 8'h00, '0,          1, 1, 8'h20, D(8'h20, 1), 0, 1, 1);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, '0,          1, 1, 8'h30, D(8'h30, 2), 0, 1, 0);
        vecs[8]  = mk(0, 8'h00, 0, 8'h00, '0,          1, 1, 8'h40, D(8'h40, 0), 0, 1, 0);
        vecs[9]  = mk(0, 8'h00, 0, 8'h00, '0,          0, 0, 8'h00, '0, 0, 1, 0);
        vecs[10] = mk(0, 8'h00, 1, 8'h60, D(8'h60, 1), 0, 0, 8'h00, '0, 0, 1, 0);
        vecs[11] = mk(0, 8'h00, 1, 8'h70, D(8'h70, 2), 1, 1, 8'h60, D(8'h60, 1), 0, 1, 0);
        vecs[12] = mk(0, 8'h00, 1, 8'h60, D(8'h60, 3), 1, 1, 8'h70, D(8'h70, 2), 0, 1, 0);
        vecs[13] = mk(0, 8'h00, 0, 8'h00, '0,          1, 1, 8'h60, D(8'h60, 3), 0, 1, 0);
        vecs[14] = mk(0, 8'h00, 0, 8'h00, '0,          0, 0, 8'h00, '0, 0, 1, 0);

        // Reset held: RAM port quiet
        tick(); tick();
        chk("rst_en", 64'(ram_en), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_gnt", 64'(rd_grant), 64'd0);
        reset = 1'b0;

        // Full power-up sweep, then lookups go straight through
        check_sweep("reset_sweep", 256);
        rd_req = 1'b1; rd_index = 8'h33;
        #1;
        chk("run_busy", 64'(busy_init), 64'd0);
        chk("run_gnt", 64'(rd_grant), 64'd1);
        chk("run_addr", 64'(ram_addr), 64'h33);
        chk("run_we", 64'(ram_we), 64'd0);
        tick();
        rd_req = 1'b0;
        #1;
        chk("run_rdv", 64'(rd_data_valid), 64'd1);
        chk("run_idle_en", 64'(ram_en), 64'd0);
        tick();

        // Flush during INIT at sweep address 100 restarts from 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_sweep("init_pre_flush", 100);
        flush_req = 1'b1;
        #1;
        chk("init_flush_addr", 64'(ram_addr), 64'd100);
        tick();
        flush_req = 1'b0;
        check_sweep("init_flush_sweep", 256);
        #1;
        chk("init_flush_done", 64'(busy_init), 64'd0);
        chk("init_flush_idle", 64'(ram_en), 64'd0);
        tick();

        // RUN arbitration, backpressure, push/pop, duplicate ordering
        for (int i = 0; i < 15; i++) begin
            rd_req = vecs[i].rd; rd_index = vecs[i].ridx;
            upd_valid = vecs[i].uv; upd_index = vecs[i].uidx; upd_data = vecs[i].ud;
            #1;
            chk($sformatf("v%0d_en", i), 64'(ram_en), 64'(vecs[i].en));
            chk($sformatf("v%0d_we", i), 64'(ram_we), 64'(vecs[i].we));
            chk($sformatf("v%0d_gnt", i), 64'(rd_grant), 64'(vecs[i].gnt));
            chk($sformatf("v%0d_rdy", i), 64'(upd_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_rdv", i), 64'(rd_data_valid), 64'(vecs[i].rdv));
            if (vecs[i].en) chk($sformatf("v%0d_addr", i), 64'(ram_addr), 64'(vecs[i].addr));
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), 64'(ram_wdata), 64'(vecs[i].wd));
            tick();
        end
        upd_valid = 1'b0;

        // Flush in RUN with three queued updates discards them
        rd_req = 1'b1; rd_index = 8'h01; upd_valid = 1'b1;
        upd_index = 8'h11; upd_data = D(8'h11, 1); tick();
        upd_index = 8'h22; upd_data = D(8'h22, 1); tick();
        upd_index = 8'h33; upd_data = D(8'h33, 1); tick();
        upd_valid = 1'b0; flush_req = 1'b1;
        #1;
        chk("run_flush_gnt", 64'(rd_grant), 64'd1);
        tick();
        flush_req = 1'b0;
        check_sweep("run_flush_sweep", 256);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_flush_idle%0d", i), 64'(ram_en), 64'd0);
            tick();
        end

        // Reset mid-FLUSH after two queued updates
        rd_req = 1'b1; upd_valid = 1'b1;
        upd_index = 8'h44; upd_data = D(8'h44, 2); tick();
        upd_index = 8'h45; upd_data = D(8'h45, 2); tick();
        upd_valid = 1'b0; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check_sweep("pre_reset_sweep", 40);
        reset = 1'b1;
        #1;
        chk("midrst_en", 64'(ram_en), 64'd0);
        chk("midrst_we", 64'(ram_we), 64'd0);
        tick(); tick();
        reset = 1'b0;
        check_sweep("post_reset_sweep", 256);
        rd_req = 1'b0;
        #1;
        chk("post_reset_rdv", 64'(rd_data_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("post_reset_idle%0d", i), 64'(ram_en), 64'd0);
            tick();
        end

        // Which indices ever reached the RAM as update writes
        chk("never_0x55", 64'(written[8'h55]), 64'd0);
        chk("never_0x11", 64'(written[8'h11]), 64'd0);
        chk("never_0x22", 64'(written[8'h22]), 64'd0);
        chk("never_0x33", 64'(written[8'h33]), 64'd0);
        chk("never_0x44", 64'(written[8'h44]), 64'd0);
        chk("never_0x45", 64'(written[8'h45]), 64'd0);
        chk("wrote_0x10", 64'(written[8'h10]), 64'd1);
        chk("wrote_0x70", 64'(written[8'h70]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
